// File: rtl/pmp_check_stage.sv
// pmp_check_stage: physical-memory-protection lookup for one request at a time.
//
// A request arrives as a toggle on i_drive, which is asynchronous to clk. The stage
// then walks the region table one entry per cycle, lowest index first, and reports
// the result with a toggle on o_free.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   i_drive            request toggle (asynchronous to clk)
//   i_addr_32, i_acc   request address and one-hot access type {x,w,r}
//   o_free             completion toggle, one per serviced request
//   o_fault, o_hit_idx result of the last request (hit index 7 = no match)
//   i_cfg_*            region write port {base, limit, perm={lock,x,w,r}}
//   o_cfg_ready        high while idle; writes are taken only then
//   o_overrun          sticky: a request was dropped because one was already queued
//
// Optional feature: define PMP_CHECK_LOCK_EN to make perm[3] lock an entry against
// rewrites until reset, and to deny W+X accesses to locked entries. Without the macro,
// perm[3] is stored but has no effect.
module pmp_check_stage #(
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_drive,
  input  logic [31:0] i_addr_32,
  input  logic [2:0]  i_acc,
  output logic        o_free,
  output logic        o_fault,
  output logic [2:0]  o_hit_idx,
  input  logic        i_cfg_we,
  input  logic [2:0]  i_cfg_idx,
  input  logic [31:0] i_cfg_base_32,
  input  logic [31:0] i_cfg_limit_32,
  input  logic [3:0]  i_cfg_perm,
  output logic        o_cfg_ready,
  output logic        o_overrun
);

  // Table is sized for the full 3-bit index so any index is in range; only the
  // first NUM_ENTRIES slots are ever written or searched.
  localparam int unsigned Slots   = 8;
  localparam logic [2:0]  LastIdx = 3'(NUM_ENTRIES - 1);
  localparam logic [2:0]  MissIdx = 3'd7;

  typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

  state_e      state_q;
  logic [2:0]  sync_q;
  logic        pend_q;
  logic        miss_q;
  logic [2:0]  idx_q;
  logic [31:0] addr_q;
  logic [2:0]  acc_q;
  logic        free_q;
  logic        fault_q;
  logic [2:0]  hit_q;
  logic        overrun_q;

  logic [31:0]      base_q  [Slots];
  logic [31:0]      limit_q [Slots];
  logic [3:0]       perm_q  [Slots];
  logic [Slots-1:0] valid_q;

  logic req_edge;
  logic cfg_ready;
  logic cfg_idx_ok;
  logic cfg_blocked;
  logic cfg_commit;
  logic entry_hit;
  logic lock_fault;
  logic access_fault;

  // sync_q[1] is the second synchronizer stage; sync_q[2] delays it for edge detection.
  assign req_edge = sync_q[1] ^ sync_q[2];

  assign cfg_ready  = (state_q == StIdle);
  assign cfg_idx_ok = (32'(i_cfg_idx) < NUM_ENTRIES);

`ifdef PMP_CHECK_LOCK_EN
  assign cfg_blocked = perm_q[i_cfg_idx][3];
  assign lock_fault  = perm_q[idx_q][3] & acc_q[2] & acc_q[1];
`else
  logic unused_lock;
  assign cfg_blocked = 1'b0;
  assign lock_fault  = 1'b0;
  always_comb begin
    unused_lock = 1'b0;
    for (int i = 0; i < Slots; i++) begin
      unused_lock = unused_lock ^ perm_q[i][3];
    end
  end
`endif

  assign cfg_commit = i_cfg_we & cfg_ready & cfg_idx_ok & ~cfg_blocked;

  // Unsigned compares; base > limit can never satisfy both, so such an entry never hits.
  assign entry_hit = valid_q[idx_q] & (base_q[idx_q] <= addr_q) & (addr_q <= limit_q[idx_q]);

  assign access_fault = miss_q | ((acc_q & perm_q[idx_q][2:0]) == 3'b000) | lock_fault;

  // Region table. A write in the same idle cycle as a request lands on the edge that
  // enters CHECK, so the walk that follows sees the new values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < Slots; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
        perm_q[i]  <= '0;
      end
    end else if (cfg_commit) begin
      base_q[i_cfg_idx]  <= i_cfg_base_32;
      limit_q[i_cfg_idx] <= i_cfg_limit_32;
      perm_q[i_cfg_idx]  <= i_cfg_perm;
      valid_q[i_cfg_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      pend_q    <= 1'b0;
      miss_q    <= 1'b0;
      idx_q     <= '0;
      addr_q    <= '0;
      acc_q     <= '0;
      free_q    <= 1'b0;
      fault_q   <= 1'b0;
      hit_q     <= MissIdx;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], i_drive};
      unique case (state_q)
        StIdle: begin
          if (req_edge || pend_q) begin
            state_q <= StCheck;
            addr_q  <= i_addr_32;
            acc_q   <= i_acc;
            idx_q   <= '0;
            // A fresh edge landing while a queued request is taken stays queued.
            pend_q  <= pend_q & req_edge;
          end
        end
        StCheck: begin
          if (req_edge) begin
            if (pend_q) overrun_q <= 1'b1;
            pend_q <= 1'b1;
          end
          if (entry_hit) begin
            miss_q  <= 1'b0;
            state_q <= StDone;
          end else if (idx_q == LastIdx) begin
            miss_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StDone: begin
          if (req_edge) begin
            if (pend_q) overrun_q <= 1'b1;
            pend_q <= 1'b1;
          end
          fault_q <= access_fault;
          hit_q   <= miss_q ? MissIdx : idx_q;
          free_q  <= ~free_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_free      = free_q;
  assign o_fault     = fault_q;
  assign o_hit_idx   = hit_q;
  assign o_overrun   = overrun_q;
  assign o_cfg_ready = cfg_ready;

endmodule

// File: tb/tb_pmp_check_stage.sv
// Bench for pmp_check_stage: directed requests with hand-computed results, plus a
// region-table model that predicts every output on every cycle.
module tb_pmp_check_stage;

  localparam int unsigned NE = 4;

  logic        clk            = 1'b0;
  logic        rstn           = 1'b0;
  logic        i_drive        = 1'b0;
  logic [31:0] i_addr_32      = '0;
  logic [2:0]  i_acc          = 3'b001;
  logic        i_cfg_we       = 1'b0;
  logic [2:0]  i_cfg_idx      = '0;
  logic [31:0] i_cfg_base_32  = '0;
  logic [31:0] i_cfg_limit_32 = '0;
  logic [3:0]  i_cfg_perm     = '0;
  logic        o_free;
  logic        o_fault;
  logic [2:0]  o_hit_idx;
  logic        o_cfg_ready;
  logic        o_overrun;

  int total  = 0;
  int bad    = 0;
  int n      = 0;  // count of clock edges seen out of reset
  int req_t0 = 0;

  pmp_check_stage #(.NUM_ENTRIES(NE)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_drive        (i_drive),
    .i_addr_32      (i_addr_32),
    .i_acc          (i_acc),
    .o_free         (o_free),
    .o_fault        (o_fault),
    .o_hit_idx      (o_hit_idx),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_idx      (i_cfg_idx),
    .i_cfg_base_32  (i_cfg_base_32),
    .i_cfg_limit_32 (i_cfg_limit_32),
    .i_cfg_perm     (i_cfg_perm),
    .o_cfg_ready    (o_cfg_ready),
    .o_overrun      (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // A request becomes visible three edges after its toggle. If the stage is idle it
  // is taken then and completes k+2 edges later (k = hit index, NE-1 on a miss);
  // otherwise it waits in a single queue slot, and a further request is dropped.
  logic [31:0] m_base  [8];
  logic [31:0] m_limit [8];
  logic [3:0]  m_perm  [8];
  logic        m_valid [8];
  logic        m_busy, m_pending, m_overrun, m_free, m_fault, m_res_fault;
  logic [2:0]  m_hit, m_res_hit;
  int          m_done;
  int          arr_q[$];

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_base[i] = '0; m_limit[i] = '0; m_perm[i] = '0; m_valid[i] = 1'b0;
    end
    m_busy = 1'b0; m_pending = 1'b0; m_overrun = 1'b0;
    m_free = 1'b0; m_fault = 1'b0; m_hit = 3'd7;
    m_res_fault = 1'b0; m_res_hit = 3'd7; m_done = 0;
    arr_q.delete();
  endfunction

  function automatic void model_start(input logic [31:0] a, input logic [2:0] acc);
    int k;
    k = -1;
    for (int i = 0; i < int'(NE); i++)
      if (k < 0 && m_valid[i] && m_base[i] <= a && a <= m_limit[i]) k = i;
    if (k < 0) begin
      m_res_hit = 3'd7; m_res_fault = 1'b1; m_done = n + int'(NE) + 1;
    end else begin
      m_res_hit   = 3'(k);
      m_res_fault = ((acc & m_perm[k][2:0]) == 3'b000);
`ifdef PMP_CHECK_LOCK_EN
      if (m_perm[k][3] && acc[2] && acc[1]) m_res_fault = 1'b1;
`endif
      m_done = n + k + 2;
    end
  endfunction

  function automatic void model_step();
    logic arrival, locked;
    n++;
    locked = 1'b0;
`ifdef PMP_CHECK_LOCK_EN
    locked = m_perm[i_cfg_idx][3];
`endif
    if (i_cfg_we && !m_busy && int'(i_cfg_idx) < int'(NE) && !locked) begin
      m_base[i_cfg_idx]  = i_cfg_base_32;
      m_limit[i_cfg_idx] = i_cfg_limit_32;
      m_perm[i_cfg_idx]  = i_cfg_perm;
      m_valid[i_cfg_idx] = 1'b1;
    end
    arrival = 1'b0;
    if (arr_q.size() > 0 && arr_q[0] == n) begin
      arrival = 1'b1;
      void'(arr_q.pop_front());
    end
    if (!m_busy) begin
      if (arrival || m_pending) begin
        model_start(i_addr_32, i_acc);
        m_busy    = 1'b1;
        m_pending = m_pending && arrival;
      end
    end else begin
      if (arrival) begin
        if (m_pending) m_overrun = 1'b1;
        else m_pending = 1'b1;
      end
      if (n == m_done) begin
        m_free  = ~m_free;
        m_fault = m_res_fault;
        m_hit   = m_res_hit;
        m_busy  = 1'b0;
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("free", o_free, m_free);
      check("fault", o_fault, m_fault);
      check("hit_idx", o_hit_idx, m_hit);
      check("overrun", o_overrun, m_overrun);
      check("cfg_ready", o_cfg_ready, !m_busy);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; i_drive = 1'b0; i_cfg_we = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [31:0] b, input logic [31:0] l,
                     input logic [3:0] p);
    i_cfg_we = 1'b1; i_cfg_idx = idx; i_cfg_base_32 = b; i_cfg_limit_32 = l; i_cfg_perm = p;
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [2:0] acc);
    i_addr_32 = a; i_acc = acc; i_drive = ~i_drive;
    req_t0 = n;
    arr_q.push_back(n + 3);
  endtask

  task automatic wait_free(output int lat);
    logic prev;
    prev = o_free;
    lat  = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_free !== prev) begin
        lat = n - req_t0;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL free_timeout: no o_free toggle within 40 cycles at t=%0t", $time);
    end
  endtask

  task automatic count_toggles(input int cycles, output int cnt);
    logic prev;
    prev = o_free;
    cnt  = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (o_free !== prev) cnt++;
      prev = o_free;
    end
  endtask

  task automatic req_check(input string name, input logic [31:0] a, input logic [2:0] acc,
                           input int exp_lat, input logic exp_fault, input logic [2:0] exp_hit);
    int lat;
    send(a, acc);
    wait_free(lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_fault"}, o_fault, exp_fault);
    check({name, "_hit"}, o_hit_idx, exp_hit);
    tick();
  endtask

  initial begin
    int lat, cnt;
    do_reset();
    check("rst_free", o_free, 1'b0);
    check("rst_fault", o_fault, 1'b0);
    check("rst_hit", o_hit_idx, 3'd7);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_ready", o_cfg_ready, 1'b1);

    cfg(3'd0, 32'h1000, 32'h1FFF, 4'b0001);
    req_check("r_ok", 32'h1800, 3'b001, 5, 1'b0, 3'd0);
    req_check("w_deny", 32'h1800, 3'b010, 5, 1'b1, 3'd0);

    cfg(3'd1, 32'h8000, 32'h8FFF, 4'b0111);
    cfg(3'd2, 32'h9000, 32'h8000, 4'b0111);  // base > limit: never matches
    cfg(3'd3, 32'h7000, 32'h9000, 4'b0001);
    req_check("overlap", 32'h8000, 3'b001, 6, 1'b0, 3'd1);
    req_check("x_ok", 32'h8004, 3'b100, 6, 1'b0, 3'd1);
    req_check("inverted", 32'h9000, 3'b001, 8, 1'b0, 3'd3);
    req_check("w_deny3", 32'h7000, 3'b010, 8, 1'b1, 3'd3);
    req_check("miss", 32'hFFFF_FFFF, 3'b100, 8, 1'b1, 3'd7);
    // Out-of-range index must be ignored.
    cfg(3'd5, 32'h0, 32'hFFFF_FFFF, 4'b0111);
    req_check("idx_oor", 32'hFFFF_FFFF, 3'b001, 8, 1'b1, 3'd7);

    // Second request during CHECK is queued, not an overrun.
    send(32'hFFFF_FFFF, 3'b001);
    repeat (2) tick();
    send(32'hFFFF_FFFF, 3'b001);
    count_toggles(30, cnt);
    check("pend_count", cnt, 2);
    check("pend_no_overrun", o_overrun, 1'b0);
    tick();

    // Third request while one is already queued is dropped and flagged.
    send(32'hFFFF_FFFF, 3'b001);
    repeat (2) tick();
    send(32'hFFFF_FFFF, 3'b001);
    repeat (2) tick();
    send(32'hFFFF_FFFF, 3'b001);
    count_toggles(40, cnt);
    check("ovr_count", cnt, 2);
    check("ovr_flag", o_overrun, 1'b1);
    tick();

    do_reset();
    cfg(3'd0, 32'h1000, 32'h1FFF, 4'b0001);

    // Write in the same cycle as the request edge: the new bounds are used.
    send(32'h4800, 3'b001);
    repeat (2) tick();
    cfg(3'd0, 32'h4000, 32'h4FFF, 4'b0001);
    wait_free(lat);
    check("same_cycle_lat", lat, 5);
    check("same_cycle_hit", o_hit_idx, 3'd0);
    check("same_cycle_fault", o_fault, 1'b0);
    tick();

    // Write during CHECK is ignored.
    send(32'hFFFF_FFFF, 3'b001);
    repeat (4) tick();
    cfg(3'd0, 32'h0, 32'hFFFF_FFFF, 4'b0111);
    wait_free(lat);
    check("busy_wr_lat", lat, 8);
    tick();
    req_check("busy_wr_keep", 32'h4800, 3'b001, 5, 1'b0, 3'd0);
    req_check("busy_wr_miss", 32'h0100, 3'b001, 8, 1'b1, 3'd7);

    cfg(3'd2, 32'h2_0000, 32'h2_FFFF, 4'b1001);
    cfg(3'd2, 32'h3_0000, 32'h3_FFFF, 4'b0111);
`ifdef PMP_CHECK_LOCK_EN
    req_check("lock_keep", 32'h2_0010, 3'b001, 7, 1'b0, 3'd2);
    req_check("lock_w", 32'h2_0010, 3'b010, 7, 1'b1, 3'd2);
    req_check("lock_new_miss", 32'h3_0010, 3'b010, 8, 1'b1, 3'd7);
`else
    req_check("nolock_new", 32'h3_0010, 3'b010, 7, 1'b0, 3'd2);
    req_check("nolock_old", 32'h2_0010, 3'b001, 8, 1'b1, 3'd7);
`endif

    // Reset in the middle of CHECK: outputs return to reset values, no completion.
    send(32'hFFFF_FFFF, 3'b001);
    repeat (5) tick();
    rstn = 1'b0; i_drive = 1'b0;
    #1;
    check("midrst_free", o_free, 1'b0);
    check("midrst_fault", o_fault, 1'b0);
    check("midrst_hit", o_hit_idx, 3'd7);
    check("midrst_overrun", o_overrun, 1'b0);
    check("midrst_ready", o_cfg_ready, 1'b1);
    repeat (2) tick();
    rstn = 1'b1;
    count_toggles(20, cnt);
    check("midrst_no_free", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
